led_matrix_scan: RTL and testbench

- Downstream display stage for the 8x8 Life grid.
- Captures each 64-bit generation presented on the game's display output and double-buffers it, so a frame is never torn.
- Time-multiplexes the buffered grid onto an 8x8 LED matrix, one row at a time, with a programmable dwell and a blanking gap for anti-ghosting.
- Emits a frame-boundary pulse that the system uses to pace generation stepping.

---
 rtl/led_matrix_scan_if.sv | 33 +++
 rtl/led_matrix_scan.sv | 195 +++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_if.sv
// Bundle between a Life engine (or bench) and the LED matrix scanner:
// grid capture inputs plus the row/column drive and status outputs.
interface led_matrix_scan_if;
    logic        enable;
    logic [63:0] grid_in;
    logic        grid_valid;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic        scanning;

    // Producer side: supplies grids and the run enable, watches the scan.
    modport master (
        output enable,
        output grid_in,
        output grid_valid,
        input  row_sel,
        input  col_data,
        input  frame_done,
        input  scanning
    );

    // Scanner side.
    modport slave (
        input  enable,
        input  grid_in,
        input  grid_valid,
        output row_sel,
        output col_data,
        output frame_done,
        output scanning
    );
endinterface

// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix row scanner for the Life grid.
// A pending buffer captures every strobed generation; the display buffer is
// refreshed from it only at the start of a frame (LOAD), so a frame never
// mixes two generations. Each row is driven for DWELL cycles followed by
// BLANK all-off cycles; frame_done pulses as the last row slot ends.
module led_matrix_scan #(
    parameter int DWELL = 50000,
    parameter int BLANK = 2
) (
    input  logic              clk,
    input  logic              reset,
    led_matrix_scan_if.slave  bus
);

    // Counter widths hold 0..DWELL-1 and 0..BLANK-1 without wrapping; the
    // blank counter keeps one bit even when blanking is disabled.
    localparam int DW       = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam int BW       = (BLANK > 1) ? $clog2(BLANK + 1) : 1;
    localparam int DWELL_M1 = (DWELL > 0) ? DWELL - 1 : 0;
    localparam int BLANK_M1 = (BLANK > 0) ? BLANK - 1 : 0;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_M1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_M1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRIVE = 2'd2,
        S_BLANK = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      row;
    logic [DW-1:0]   dwell_cnt;
    logic [BW-1:0]   blank_cnt;
    logic [63:0]     pending;
    logic [63:0]     display;
    logic            pending_flag;
    logic            have_frame;

    logic [7:0]      row_sel_reg;
    logic [7:0]      col_data_reg;
    logic            frame_done_reg;
    logic            scanning_reg;

    logic            dwell_last;
    logic            blank_last;
    logic            slot_end;
    logic            load_copy;
    logic [2:0]      next_row;
    logic [7:0]      display_rows [8];

    // Slice the display buffer into per-row column words.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rows
            assign display_rows[gi] = display[8*gi +: 8];
        end
    endgenerate

    // Slot timing decodes shared by the FSM and the buffer logic.
    always_comb begin
        dwell_last = (dwell_cnt == DWELL_LAST);
        blank_last = (blank_cnt == BLANK_LAST);
        slot_end   = 1'b0;
        if (state == S_DRIVE && dwell_last && BLANK == 0) begin
            slot_end = 1'b1;
        end
        if (state == S_BLANK && blank_last) begin
            slot_end = 1'b1;
        end
        load_copy = (state == S_LOAD) && pending_flag;
        next_row  = row + 3'd1;
    end

    // Capture: any strobe lands in the pending buffer (last one wins). A
    // strobe coinciding with a LOAD copy keeps the flag set so the new grid
    // is picked up on the following frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            pending_flag <= 1'b0;
            have_frame   <= 1'b0;
        end else if (bus.grid_valid) begin
            pending      <= bus.grid_in;
            pending_flag <= 1'b1;
            have_frame   <= 1'b1;
        end else if (load_copy) begin
            pending_flag <= 1'b0;
        end
    end

    // Display buffer: refreshed only at the frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display <= '0;
        end else if (load_copy) begin
            display <= pending;
        end
    end

    // Scan FSM with registered outputs; each output register is loaded with
    // the value belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            row            <= 3'd0;
            dwell_cnt      <= '0;
            blank_cnt      <= '0;
            row_sel_reg    <= 8'h00;
            col_data_reg   <= 8'h00;
            frame_done_reg <= 1'b0;
            scanning_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    row_sel_reg  <= 8'h00;
                    col_data_reg <= 8'h00;
                    if (bus.enable && have_frame) begin
                        state        <= S_LOAD;
                        scanning_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Row 0 data comes from whichever buffer is current
                    // after this cycle's copy.
                    row          <= 3'd0;
                    dwell_cnt    <= '0;
                    state        <= S_DRIVE;
                    row_sel_reg  <= 8'h01;
                    col_data_reg <= load_copy ? pending[7:0] : display_rows[0];
                end
                S_DRIVE: begin
                    if (dwell_last) begin
                        if (BLANK > 0) begin
                            state        <= S_BLANK;
                            blank_cnt    <= '0;
                            row_sel_reg  <= 8'h00;
                            col_data_reg <= 8'h00;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                S_BLANK: begin
                    if (!blank_last) begin
                        blank_cnt <= blank_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // End of a row slot: advance to the next row, or close the frame.
            if (slot_end) begin
                if (row != 3'd7) begin
                    row          <= next_row;
                    dwell_cnt    <= '0;
                    state        <= S_DRIVE;
                    row_sel_reg  <= 8'h01 << next_row;
                    col_data_reg <= display_rows[next_row];
                end else begin
                    frame_done_reg <= 1'b1;
                    row_sel_reg    <= 8'h00;
                    col_data_reg   <= 8'h00;
                    state          <= bus.enable ? S_LOAD : S_IDLE;
                    scanning_reg   <= bus.enable;
                end
            end
        end
    end

    assign bus.row_sel    = row_sel_reg;
    assign bus.col_data   = col_data_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.scanning   = scanning_reg;

    // At most one row is ever driven.
    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(row_sel_reg))
                else $error("row_sel not one-hot");
        end
    end

    // Columns are dark whenever no row is selected.
    always @(posedge clk) begin
        if (!reset && row_sel_reg == 8'h00) begin
            assert (col_data_reg == 8'h00)
                else $error("col_data active with no row selected");
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL=4, BLANK=1 (41-cycle frame).
module tb_led_matrix_scan;

    localparam int DWELL = 4;
    localparam int BLANK = 1;

    localparam logic [63:0] G_DIAG = 64'h8040201008040201;
    localparam logic [63:0] G_FULL = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] G_AA   = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] G_MIX  = 64'h0123_4567_89AB_CDEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    led_matrix_scan_if bus ();

    led_matrix_scan #(
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    // Strobes are one cycle wide, so grid_valid drops after every edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.grid_valid = 1'b0;
    endtask

    task automatic strobe(input logic [63:0] g);
        bus.grid_in    = g;
        bus.grid_valid = 1'b1;
    endtask

    // Wait (bounded) for the scanner to leave IDLE; expected latency given.
    task automatic wait_load(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!bus.scanning && lat < 20) begin
            tick();
            lat++;
        end
        check_val({tag, " reached LOAD"}, 64'(bus.scanning), 64'd1);
        check_val({tag, " LOAD latency"}, 64'(lat), 64'(exp_lat));
    endtask

    // Starting in a LOAD cycle, checks a full frame showing grid g and the
    // closing frame_done. act_kind 1 strobes act_grid, 2 drops enable, both
    // at the first dwell cycle of act_row.
    task automatic run_frame(input string fname, input logic [63:0] g,
                             input int act_row, input int act_kind,
                             input logic [63:0] act_grid);
        logic [7:0] one_hot;
        check_val({fname, " LOAD row_sel"}, 64'(bus.row_sel), 64'd0);
        check_val({fname, " LOAD scanning"}, 64'(bus.scanning), 64'd1);
        for (int r = 0; r < 8; r++) begin
            one_hot = 8'(1 << r);
            for (int d = 0; d < DWELL; d++) begin
                tick();
                check_val($sformatf("%s r%0d d%0d row_sel", fname, r, d),
                          64'(bus.row_sel), 64'(one_hot));
                check_val($sformatf("%s r%0d d%0d col_data", fname, r, d),
                          64'(bus.col_data), 64'(g[8*r +: 8]));
                check_val($sformatf("%s r%0d d%0d frame_done", fname, r, d),
                          64'(bus.frame_done), 64'd0);
                if (r == act_row && d == 0) begin
                    if (act_kind == 1) strobe(act_grid);
                    if (act_kind == 2) bus.enable = 1'b0;
                end
            end
            for (int b = 0; b < BLANK; b++) begin
                tick();
                check_val($sformatf("%s r%0d blank row_sel", fname, r),
                          64'(bus.row_sel), 64'd0);
                check_val($sformatf("%s r%0d blank col_data", fname, r),
                          64'(bus.col_data), 64'd0);
            end
        end
        tick();
        check_val({fname, " frame_done"}, 64'(bus.frame_done), 64'd1);
        check_val({fname, " end row_sel"}, 64'(bus.row_sel), 64'd0);
        check_val({fname, " end scanning"}, 64'(bus.scanning), 64'(bus.enable));
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check_val($sformatf("%s c%0d row_sel", tag, i), 64'(bus.row_sel), 64'd0);
            check_val($sformatf("%s c%0d col_data", tag, i), 64'(bus.col_data), 64'd0);
            check_val($sformatf("%s c%0d scanning", tag, i), 64'(bus.scanning), 64'd0);
            check_val($sformatf("%s c%0d frame_done", tag, i), 64'(bus.frame_done), 64'd0);
        end
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.enable     = 1'b0;
        bus.grid_in    = '0;
        bus.grid_valid = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset row_sel", 64'(bus.row_sel), 64'd0);
        check_val("reset col_data", 64'(bus.col_data), 64'd0);
        check_val("reset frame_done", 64'(bus.frame_done), 64'd0);
        check_val("reset scanning", 64'(bus.scanning), 64'd0);

        // Enabled but no grid yet: must stay idle.
        reset      = 1'b0;
        bus.enable = 1'b1;
        check_idle("idle nogrid", 8);

        // First grid: captured on one edge, LOAD entered on the next.
        strobe(G_DIAG);
        tick();
        check_val("capture still idle", 64'(bus.scanning), 64'd0);
        wait_load("first", 1);

        // Frame A: diagonal, with an all-ones strobe during row 3.
        run_frame("A", G_DIAG, 3, 1, G_FULL);
        // Frame B: all ones; a diagonal strobe during row 5 leaves it pending.
        run_frame("B", G_FULL, 5, 1, G_DIAG);
        // Collision: new strobe in the LOAD cycle that copies the diagonal.
        strobe(G_AA);
        run_frame("C", G_DIAG, -1, 0, '0);
        // Frame D shows 0xAA; enable drops during row 2, frame still completes.
        run_frame("D", G_AA, 2, 2, '0);
        check_idle("idle disabled", 5);

        // Re-enable: existing frame restarts scanning on the next edge.
        bus.enable = 1'b1;
        tick();
        wait_load("reenable", 0);
        run_frame("E", G_AA, -1, 0, '0);

        // Move into row 1 drive, then pulse reset between clock edges.
        repeat (7) tick();
        check_val("pre-reset row_sel", 64'(bus.row_sel), 64'h02);
        #2;
        reset = 1'b1;
        #1;
        check_val("async reset row_sel", 64'(bus.row_sel), 64'd0);
        check_val("async reset col_data", 64'(bus.col_data), 64'd0);
        check_val("async reset scanning", 64'(bus.scanning), 64'd0);
        #2;
        reset = 1'b0;
        check_idle("idle after reset", 6);

        // A fresh grid restarts the scanner.
        strobe(G_MIX);
        tick();
        wait_load("after reset", 1);
        run_frame("F", G_MIX, -1, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
